// File: rtl/spi_rr_arbiter.sv
// rtl/spi_rr_arbiter.sv - round-robin arbiter sharing one spi32 engine between NREQ requesters
// Replays the winner's command into spi32, tracks busy with a per-phase watchdog, routes chip select.
module spi_rr_arbiter #(
   parameter int NREQ    = 4,
   parameter int TIMEOUT = 1024,
   parameter int TW      = 11
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [NREQ-1:0]      req,
   input  logic [NREQ-1:0]      req_wr,
   input  logic [32*NREQ-1:0]   req_din,
   input  logic [2*NREQ-1:0]    req_nbytes,
   output logic [NREQ-1:0]      grant,
   output logic [NREQ-1:0]      done,
   output logic [NREQ-1:0]      err,
   output logic [31:0]          rdata,
   output logic                 arb_busy,
   output logic                 spi_read,
   output logic                 spi_write,
   output logic [31:0]          spi_din,
   output logic [1:0]           spi_nbytes,
   input  logic [31:0]          spi_dout,
   input  logic                 spi_busy,
   input  logic                 spi_cs,
   output logic [NREQ-1:0]      dev_cs_n
);

   localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

   typedef enum logic [2:0] {
      S_IDLE, S_GRANT, S_ISSUE, S_WAIT_BUSY, S_WAIT_DONE, S_COMPLETE
   } state_t;

   state_t            r_state;
   state_t            w_next;
   logic [IW-1:0]     r_owner;
   logic [IW-1:0]     r_rr_ptr;
   logic              r_wr;
   logic              r_err;
   logic [31:0]       r_din;
   logic [1:0]        r_nbytes;
   logic [NREQ-1:0]   r_grant;
   logic              r_spi_read;
   logic              r_spi_write;
   logic [TW-1:0]     r_wd;

   logic [IW-1:0]     w_sel;
   logic              w_found;
   logic              w_wd_hit;
   logic [NREQ-1:0]   w_owner_oh;
   logic [31:0]       w_din_arr    [NREQ];
   logic [1:0]        w_nbytes_arr [NREQ];

   for (genvar g = 0; g < NREQ; g++) begin : g_unpack
      assign w_din_arr[g]    = req_din[32*g +: 32];
      assign w_nbytes_arr[g] = req_nbytes[2*g +: 2];
   end

   assign w_wd_hit   = (r_wd == TW'(TIMEOUT - 1));
   assign w_owner_oh = NREQ'(1) << r_owner;

   // Scan downward so the lowest offset from the pointer wins last.
   always_comb begin : p_select
      logic [IW-1:0] idx;
      w_sel   = '0;
      w_found = 1'b0;
      idx     = '0;
      for (int k = NREQ - 1; k >= 0; k--) begin
         idx = IW'((int'(r_rr_ptr) + k) % NREQ);
         if (req[idx]) begin
            w_sel   = idx;
            w_found = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:      if (w_found && !spi_busy) w_next = S_GRANT;
         S_GRANT:     w_next = S_ISSUE;
         S_ISSUE:     w_next = S_WAIT_BUSY;
         S_WAIT_BUSY: if (spi_busy)      w_next = S_WAIT_DONE;
                      else if (w_wd_hit) w_next = S_COMPLETE;
         S_WAIT_DONE: if (!spi_busy || w_wd_hit) w_next = S_COMPLETE;
         S_COMPLETE:  w_next = S_IDLE;
         default:     w_next = S_IDLE;
      endcase
   end

   always_comb begin
      arb_busy = (r_state != S_IDLE);
      done     = '0;
      err      = '0;
      rdata    = '0;
      if (r_state == S_COMPLETE) begin
         done  = w_owner_oh;
         err   = r_err ? w_owner_oh : '0;
         rdata = r_err ? 32'd0 : spi_dout;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_owner     <= '0;
         r_rr_ptr    <= '0;
         r_wr        <= 1'b0;
         r_err       <= 1'b0;
         r_din       <= '0;
         r_nbytes    <= '0;
         r_grant     <= '0;
         r_spi_read  <= 1'b0;
         r_spi_write <= 1'b0;
         r_wd        <= '0;
      end else begin
         r_spi_read  <= 1'b0;
         r_spi_write <= 1'b0;
         case (r_state)
            S_IDLE: if (w_next == S_GRANT) begin
               r_owner  <= w_sel;
               r_wr     <= req_wr[w_sel];
               r_din    <= w_din_arr[w_sel];
               r_nbytes <= w_nbytes_arr[w_sel];
            end
            S_GRANT: r_grant <= w_owner_oh;
            S_ISSUE: begin
               r_spi_write <= r_wr;
               r_spi_read  <= !r_wr;
               r_wd        <= '0;
            end
            S_WAIT_BUSY: begin
               if (spi_busy)          r_wd  <= '0;
               else if (w_wd_hit)     r_err <= 1'b1;
               else if (r_wd != '1)   r_wd  <= r_wd + TW'(1);
            end
            S_WAIT_DONE: begin
               if (!spi_busy)         r_wd  <= r_wd;
               else if (w_wd_hit)     r_err <= 1'b1;
               else if (r_wd != '1)   r_wd  <= r_wd + TW'(1);
            end
            S_COMPLETE: begin
               r_rr_ptr <= (r_owner == IW'(NREQ - 1)) ? '0 : r_owner + IW'(1);
               r_grant  <= '0;
               r_err    <= 1'b0;
            end
            default: ;
         endcase
      end
   end

   assign grant      = r_grant;
   assign spi_read   = r_spi_read;
   assign spi_write  = r_spi_write;
   assign spi_din    = r_din;
   assign spi_nbytes = r_nbytes;
   assign dev_cs_n   = ~r_grant | {NREQ{spi_cs}};

endmodule

// File: tb/tb_spi_rr_arbiter.sv
// tb/tb_spi_rr_arbiter.sv - directed bench for spi_rr_arbiter with a behavioural spi32 busy model
// A second instance with TIMEOUT=16 and spi_busy stuck low exercises the watchdog.
module tb_spi_rr_arbiter;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic [3:0]    req = '0;
   logic [3:0]    req_wr = '0;
   logic [127:0]  req_din = '0;
   logic [7:0]    req_nbytes = '0;
   logic [3:0]    grant, done, err, dev_cs_n;
   logic [31:0]   rdata, spi_din;
   logic          arb_busy, spi_read, spi_write, spi_busy, spi_cs;
   logic [1:0]    spi_nbytes;
   logic [31:0]   m_dout = '0;

   logic [3:0]    t_req = '0;
   logic [3:0]    t_grant, t_done, t_err, t_dev_cs_n;
   logic [31:0]   t_rdata, t_spi_din;
   logic          t_arb_busy, t_spi_read, t_spi_write;
   logic [1:0]    t_spi_nbytes;

   int            n_checks = 0;
   int            n_fail = 0;
   int            busy_len = 1;
   int            both_cnt = 0;
   logic [7:0]    m_cnt;

   always #5 clk = ~clk;

   spi_rr_arbiter #(.NREQ(4), .TIMEOUT(1024), .TW(11)) u_dut (
      .clk(clk), .reset(reset), .req(req), .req_wr(req_wr), .req_din(req_din),
      .req_nbytes(req_nbytes), .grant(grant), .done(done), .err(err), .rdata(rdata),
      .arb_busy(arb_busy), .spi_read(spi_read), .spi_write(spi_write), .spi_din(spi_din),
      .spi_nbytes(spi_nbytes), .spi_dout(m_dout), .spi_busy(spi_busy), .spi_cs(spi_cs),
      .dev_cs_n(dev_cs_n)
   );

   spi_rr_arbiter #(.NREQ(4), .TIMEOUT(16), .TW(5)) u_dut_to (
      .clk(clk), .reset(reset), .req(t_req), .req_wr(req_wr), .req_din(req_din),
      .req_nbytes(req_nbytes), .grant(t_grant), .done(t_done), .err(t_err), .rdata(t_rdata),
      .arb_busy(t_arb_busy), .spi_read(t_spi_read), .spi_write(t_spi_write),
      .spi_din(t_spi_din), .spi_nbytes(t_spi_nbytes), .spi_dout(32'h1234_5678),
      .spi_busy(1'b0), .spi_cs(1'b1), .dev_cs_n(t_dev_cs_n)
   );

   // spi32 stand-in: busy for busy_len cycles after a command, cs low while busy.
   always @(posedge clk or posedge reset) begin
      if (reset)                       m_cnt <= '0;
      else if (spi_read || spi_write)  m_cnt <= 8'(busy_len);
      else if (m_cnt != 0)             m_cnt <= m_cnt - 8'd1;
   end
   assign spi_busy = (m_cnt != 0);
   assign spi_cs   = ~spi_busy;

   always @(negedge clk) if (spi_read && spi_write) both_cnt <= both_cnt + 1;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got=0x%08h exp=0x%08h", tag, got, exp);
      end
   endtask

   task automatic wait_done(input int maxc, output logic ok);
      ok = 1'b0;
      for (int i = 0; i < maxc; i++) begin
         @(negedge clk);
         if (|done) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   logic       ok;
   int         k;
   logic [3:0] exp_fair [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

   initial begin
      repeat (2) @(negedge clk);
      check_eq("rst_grant", grant, 0);
      check_eq("rst_done", done, 0);
      check_eq("rst_err", err, 0);
      check_eq("rst_rdata", rdata, 0);
      check_eq("rst_rd", spi_read, 0);
      check_eq("rst_wr", spi_write, 0);
      check_eq("rst_din", spi_din, 0);
      check_eq("rst_nbytes", spi_nbytes, 0);
      check_eq("rst_cs", dev_cs_n, 4'hF);
      check_eq("rst_busy", arb_busy, 0);
      reset = 1'b0;

      // single write from requester 2
      @(negedge clk);
      req_wr[2] = 1'b1;
      req_din[64 +: 32] = 32'hDEAD_BEEF;
      req_nbytes[4 +: 2] = 2'd3;
      busy_len = 40;
      req = 4'b0100;
      @(negedge clk);
      check_eq("w_grant_early", grant, 0);
      check_eq("w_arb_busy", arb_busy, 1);
      req_din[64 +: 32] = 32'h0BAD_0BAD;
      @(negedge clk);
      check_eq("w_grant", grant, 4'b0100);
      check_eq("w_pulse_early", spi_write, 0);
      @(negedge clk);
      check_eq("w_pulse", spi_write, 1);
      check_eq("w_no_read", spi_read, 0);
      check_eq("w_din", spi_din, 32'hDEAD_BEEF);
      check_eq("w_nbytes", spi_nbytes, 3);
      @(negedge clk);
      check_eq("w_pulse_end", spi_write, 0);
      check_eq("w_dev_cs", dev_cs_n, 4'b1011);
      wait_done(200, ok);
      check_eq("w_done_seen", ok, 1);
      check_eq("w_done", done, 4'b0100);
      check_eq("w_err", err, 0);
      req = 4'b0000;
      @(negedge clk);
      check_eq("w_done_1cyc", done, 0);
      check_eq("w_grant_clr", grant, 0);

      // read from requester 0
      req_wr[0] = 1'b0;
      m_dout = 32'h0000_00A5;
      busy_len = 3;
      req = 4'b0001;
      wait_done(50, ok);
      check_eq("r_done_seen", ok, 1);
      check_eq("r_done", done, 4'b0001);
      check_eq("r_rdata", rdata, 32'h0000_00A5);
      check_eq("r_err", err, 0);
      req = 4'b0000;

      // fairness: all four held from reset
      @(negedge clk);
      reset = 1'b1;
      req_wr = 4'b0000;
      busy_len = 2;
      req = 4'b1111;
      @(negedge clk);
      reset = 1'b0;
      for (int i = 0; i < 5; i++) begin
         wait_done(50, ok);
         check_eq($sformatf("fair_seen%0d", i), ok, 1);
         check_eq($sformatf("fair_order%0d", i), done, exp_fair[i]);
      end
      req = 4'b0000;

      // pointer wrap: serve 3, then 1 and 3 pending
      @(negedge clk);
      req = 4'b1000;
      wait_done(50, ok);
      check_eq("wrap_done3", done, 4'b1000);
      req = 4'b1010;
      wait_done(50, ok);
      check_eq("wrap_first", done, 4'b0010);
      req = 4'b1000;
      wait_done(50, ok);
      check_eq("wrap_second", done, 4'b1000);
      req = 4'b0000;

      // watchdog on the TIMEOUT=16 instance
      @(negedge clk);
      t_req = 4'b0010;
      k = 0;
      while (!t_spi_read && k < 10) begin
         @(negedge clk);
         k++;
      end
      check_eq("to_pulse_seen", t_spi_read, 1);
      k = 0;
      while (!(|t_done) && k < 100) begin
         @(negedge clk);
         k++;
      end
      check_eq("to_latency", k, 16);
      check_eq("to_done", t_done, 4'b0010);
      check_eq("to_err", t_err, 4'b0010);
      check_eq("to_rdata", t_rdata, 0);
      t_req = 4'b0000;

      // reset during WAIT_DONE
      @(negedge clk);
      req_wr[2] = 1'b0;
      busy_len = 40;
      req = 4'b0100;
      k = 0;
      while (!spi_busy && k < 10) begin
         @(negedge clk);
         k++;
      end
      check_eq("mid_busy_seen", spi_busy, 1);
      repeat (2) @(negedge clk);
      reset = 1'b1;
      req = 4'b0000;
      #1;
      check_eq("mid_grant", grant, 0);
      check_eq("mid_cs", dev_cs_n, 4'hF);
      check_eq("mid_done", done, 0);
      check_eq("mid_arb", arb_busy, 0);
      @(negedge clk);
      check_eq("mid_done_hold", done, 0);
      reset = 1'b0;
      req_wr[2] = 1'b1;
      req_din[64 +: 32] = 32'h1122_3344;
      req_nbytes[4 +: 2] = 2'd2;
      busy_len = 5;
      req = 4'b0100;
      wait_done(50, ok);
      check_eq("post_done", done, 4'b0100);
      check_eq("post_err", err, 0);
      check_eq("post_din", spi_din, 32'h1122_3344);
      req = 4'b0000;
      @(negedge clk);

      check_eq("rd_wr_excl", both_cnt, 0);
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
